xsim_reset_seq: RTL and testbench

- Simulation-top sequencing stage. It sits between the simulator clock source and the generated BSV top (mkXsimTop).
- Holds the DUT reset for a programmable number of cycles, then releases it.
- Runs a free cycle counter.
- Turns a finish request from the DPI poll into an orderly shutdown: quiesce handshake with the DUT, then a single sim_done pulse that the top uses to call $finish.

---
 rtl/xsim_reset_seq_pkg.sv | 21 ++
 rtl/xsim_reset_seq_if.sv | 37 +++
 rtl/xsim_sat_counter.sv | 24 ++
 rtl/xsim_reset_seq.sv | 102 ++++++++++
 tb/tb_xsim_reset_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/xsim_reset_seq_pkg.sv
// Shared types and defaults for the simulation-top reset/finish sequencer.
// Package name xsim_seq_pkg; imported by the interface, counter and top.
package xsim_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int SEQ_DEFAULT_RESET_CYCLES  = 20;
  localparam int SEQ_DEFAULT_CNT_W         = 32;
  localparam int SEQ_DEFAULT_DRAIN_TIMEOUT = 1024;

  // Bits needed to count 0 .. tc-1.
  function automatic int cnt_width(input int tc);
    return (tc > 1) ? $clog2(tc) : 1;
  endfunction

endpackage

// File: rtl/xsim_reset_seq_if.sv
// Handshake bundle between the sequencer (master) and the sim top / DUT (slave).
// drain_timeout exists only when XSIM_RESET_SEQ_TIMEOUT_EN is defined.
interface xsim_reset_seq_if
  import xsim_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_DEFAULT_CNT_W
);
  logic             finish_req;
  logic             soft_rst_req;
  logic             quiesce_ack;
  logic             core_rst_n;
  logic             quiesce_req;
  logic             sim_done;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       state_o;
`ifdef XSIM_RESET_SEQ_TIMEOUT_EN
  logic             drain_timeout;

  modport master (
    input  finish_req, soft_rst_req, quiesce_ack,
    output core_rst_n, quiesce_req, sim_done, cycle_count, state_o, drain_timeout
  );
  modport slave (
    output finish_req, soft_rst_req, quiesce_ack,
    input  core_rst_n, quiesce_req, sim_done, cycle_count, state_o, drain_timeout
  );
`else
  modport master (
    input  finish_req, soft_rst_req, quiesce_ack,
    output core_rst_n, quiesce_req, sim_done, cycle_count, state_o
  );
  modport slave (
    output finish_req, soft_rst_req, quiesce_ack,
    input  core_rst_n, quiesce_req, sim_done, cycle_count, state_o
  );
`endif
endinterface

// File: rtl/xsim_sat_counter.sv
// Counter with clear that saturates at TC-1 and flags it on tc.
// Used for the reset-hold and drain-timeout intervals.
module xsim_sat_counter
  import xsim_seq_pkg::*;
#(
  parameter int TC = SEQ_DEFAULT_RESET_CYCLES,
  localparam int W = cnt_width(TC)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/xsim_reset_seq.sv
// Sim-top sequencer: holds core reset, runs a free cycle counter, and turns a
// finish request into quiesce + one sim_done pulse. Option: XSIM_RESET_SEQ_TIMEOUT_EN.
module xsim_reset_seq
  import xsim_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = SEQ_DEFAULT_RESET_CYCLES,
  parameter int CNT_W         = SEQ_DEFAULT_CNT_W,
  parameter int DRAIN_TIMEOUT = SEQ_DEFAULT_DRAIN_TIMEOUT
) (
  input logic              CLK,
  input logic              RST_N,
  xsim_reset_seq_if.master bus
);
  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("xsim_reset_seq: RESET_CYCLES must be at least 1");
  end
  if (DRAIN_TIMEOUT < 1) begin : g_bad_drain_timeout
    $error("xsim_reset_seq: DRAIN_TIMEOUT must be at least 1");
  end

  seq_state_t       state_q, state_d;
  logic             pend_q;
  logic             core_rst_q, qreq_q, done_q;
  logic [CNT_W-1:0] cyc_q;
  logic             hold_tc;
  logic             drain_tc;

  xsim_sat_counter #(.TC(RESET_CYCLES)) u_hold_cnt (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (state_q != HOLD),
    .en   (state_q == HOLD),
    .tc   (hold_tc)
  );

`ifdef XSIM_RESET_SEQ_TIMEOUT_EN
  logic to_q;

  xsim_sat_counter #(.TC(DRAIN_TIMEOUT)) u_drain_cnt (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (state_q != DRAIN),
    .en   (state_q == DRAIN),
    .tc   (drain_tc)
  );

  // Ack on the same edge as the timeout wins; the flag marks a real give-up only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) to_q <= 1'b0;
    else if (state_q == DRAIN && !bus.quiesce_ack && drain_tc) to_q <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RST_N && state_q == DRAIN && !bus.quiesce_ack && drain_tc)
      $display("xsim_reset_seq: drain timeout");
  end
`endif

  assign bus.drain_timeout = to_q;
`else
  assign drain_tc = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (hold_tc) state_d = RUN;
      // Finish (live or latched during hold) beats a concurrent soft reset.
      RUN:     if (bus.finish_req || pend_q) state_d = DRAIN;
               else if (bus.soft_rst_req)     state_d = HOLD;
      DRAIN:   if (bus.quiesce_ack || drain_tc) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= HOLD;
      pend_q     <= 1'b0;
      core_rst_q <= 1'b0;
      qreq_q     <= 1'b0;
      done_q     <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_q | (state_q == HOLD && bus.finish_req);
      core_rst_q <= (state_d != HOLD);
      qreq_q     <= (state_d == DRAIN) || (state_d == DONE);
      done_q     <= (state_d == DONE) && (state_q != DONE);
      cyc_q      <= cyc_q + 1'b1;
    end
  end

  assign bus.core_rst_n  = core_rst_q;
  assign bus.quiesce_req = qreq_q;
  assign bus.sim_done    = done_q;
  assign bus.cycle_count = cyc_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_xsim_reset_seq.sv
// Bench for xsim_reset_seq: scenarios are described by event cycles and the
// expected outputs are derived from those event times arithmetically.
module tb_xsim_reset_seq;
  localparam int RC  = 20;
  localparam int CW  = 32;
  localparam int DT  = 8;
  localparam int NEV = 1000000;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  xsim_reset_seq_if #(.CNT_W(CW)) bus ();

  xsim_reset_seq #(.RESET_CYCLES(RC), .CNT_W(CW), .DRAIN_TIMEOUT(DT)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    RST_N = 1'b0;
    bus.finish_req   = 1'b0;
    bus.soft_rst_req = 1'b0;
    bus.quiesce_ack  = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  // s: soft pulse cycle, f: finish rise cycle, a: ack rise cycle (NEV = never).
  // An input set at cycle c is sampled on edge c+1.
  task automatic run_scenario(input string name, input int s, input int f, input int a, input int n);
    int fall, hold_end, d, dn, aa, k;
    bit tof, e_drain, e_rst;
    logic [1:0] e_st;
    fall = NEV; hold_end = RC;
    if (s < NEV && s >= RC && f > s) begin
      fall = s + 1; hold_end = s + 1 + RC;
    end
    if (f == NEV)                              d = NEV;
    else if (f + 1 <= RC)                      d = RC + 1;
    else if (f + 1 > fall && f + 1 <= hold_end) d = hold_end + 1;
    else                                       d = f + 1;
    aa  = (a == NEV) ? NEV : a + 1;
    dn  = (d == NEV) ? NEV : ((aa > d + 1) ? aa : d + 1);
    tof = 1'b0;
`ifdef XSIM_RESET_SEQ_TIMEOUT_EN
    if (d != NEV && dn > d + DT) begin dn = d + DT; tof = 1'b1; end
`endif
    apply_reset();
    bus.finish_req   = (0 >= f);
    bus.soft_rst_req = (s == 0);
    bus.quiesce_ack  = (0 >= a);
    for (k = 1; k <= n; k++) begin
      @(posedge CLK); #1;
      e_drain = (k >= d);
      e_rst   = !(k < RC || (k >= fall && k < hold_end));
      e_st    = (k >= dn) ? 2'd3 : e_drain ? 2'd2 : e_rst ? 2'd1 : 2'd0;
      n_chk += 5;
      if (bus.cycle_count !== CW'(k)) begin
        n_fail++; $display("FAIL %s cycle_count k=%0d got %0d expected %0d", name, k, bus.cycle_count, k);
      end
      if (bus.core_rst_n !== e_rst) begin
        n_fail++; $display("FAIL %s core_rst_n k=%0d got %b expected %b", name, k, bus.core_rst_n, e_rst);
      end
      if (bus.quiesce_req !== e_drain) begin
        n_fail++; $display("FAIL %s quiesce_req k=%0d got %b expected %b", name, k, bus.quiesce_req, e_drain);
      end
      if (bus.sim_done !== (k == dn)) begin
        n_fail++; $display("FAIL %s sim_done k=%0d got %b expected %b", name, k, bus.sim_done, (k == dn));
      end
      if (bus.state_o !== e_st) begin
        n_fail++; $display("FAIL %s state_o k=%0d got %0d expected %0d", name, k, bus.state_o, e_st);
      end
`ifdef XSIM_RESET_SEQ_TIMEOUT_EN
      n_chk++;
      if (bus.drain_timeout !== (tof && k >= dn)) begin
        n_fail++; $display("FAIL %s drain_timeout k=%0d got %b expected %b", name, k, bus.drain_timeout, (tof && k >= dn));
      end
`endif
      bus.finish_req   = (k >= f);
      bus.soft_rst_req = (k == s);
      bus.quiesce_ack  = (k >= a);
    end
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    bus.finish_req = 1'b0; bus.soft_rst_req = 1'b0; bus.quiesce_ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_chk += 4;
    if (bus.core_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset core_rst_n got %b expected 0", bus.core_rst_n); end
    if (bus.quiesce_req !== 1'b0 || bus.sim_done !== 1'b0) begin
      n_fail++; $display("FAIL reset qreq/done got %b/%b expected 0/0", bus.quiesce_req, bus.sim_done);
    end
    if (bus.cycle_count !== '0) begin n_fail++; $display("FAIL reset cycle_count got %0d expected 0", bus.cycle_count); end
    if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL reset state_o got %0d expected 0", bus.state_o); end
  endtask

  task automatic test_release();          run_scenario("release", NEV, NEV, NEV, 40); endtask
  task automatic test_finish();           run_scenario("finish", NEV, 40, 45, 60);    endtask
  task automatic test_ack_early();        run_scenario("ack_early", NEV, 40, 10, 50); endtask
  task automatic test_soft_reset();       run_scenario("soft_reset", 30, NEV, NEV, 70); endtask
  task automatic test_soft_then_finish(); run_scenario("soft_then_fin", 30, 40, 55, 70); endtask
  task automatic test_finish_and_soft();  run_scenario("fin_and_soft", 35, 35, 39, 50); endtask
  task automatic test_finish_in_hold();   run_scenario("fin_in_hold", NEV, 10, 30, 40); endtask

  task automatic test_random();
    int s, f, a;
    for (int i = 0; i < 8; i++) begin
      s = ($urandom_range(0, 3) == 0) ? NEV : int'($urandom_range(RC, 60));
      f = ($urandom_range(0, 4) == 0) ? NEV : int'($urandom_range(0, 80));
      a = ($urandom_range(0, 4) == 0) ? NEV : int'($urandom_range(0, 100));
      run_scenario($sformatf("random%0d", i), s, f, a, 110);
    end
  endtask

`ifdef XSIM_RESET_SEQ_TIMEOUT_EN
  task automatic test_timeout(); run_scenario("timeout", NEV, 30, NEV, 50); endtask
`endif

  task automatic test_midrain_reset();
    // Finish in hold leaves the pending bit set; DRAIN starts at edge RC+1.
    run_scenario("midrain_pre", NEV, 5, NEV, RC + 3);
    #2 RST_N = 1'b0;
    #1;
    n_chk += 3;
    if (bus.core_rst_n !== 1'b0 || bus.quiesce_req !== 1'b0 || bus.sim_done !== 1'b0) begin
      n_fail++; $display("FAIL midrain outputs rst/qreq/done got %b/%b/%b expected 0/0/0",
                         bus.core_rst_n, bus.quiesce_req, bus.sim_done);
    end
    if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL midrain state_o got %0d expected 0", bus.state_o); end
    if (bus.cycle_count !== '0) begin n_fail++; $display("FAIL midrain cycle_count got %0d expected 0", bus.cycle_count); end
    bus.finish_req = 1'b0;
    bus.quiesce_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      n_chk++;
      if (bus.sim_done !== 1'b0 || bus.state_o !== 2'd0) begin
        n_fail++; $display("FAIL midrain_hold i=%0d done/state got %b/%0d expected 0/0", i, bus.sim_done, bus.state_o);
      end
    end
    run_scenario("midrain_post", NEV, NEV, NEV, RC + 10);
  endtask

  initial begin
    test_reset();
    test_release();
    test_finish();
    test_ack_early();
    test_soft_reset();
    test_soft_then_finish();
    test_finish_and_soft();
    test_finish_in_hold();
    test_midrain_reset();
`ifdef XSIM_RESET_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
